// File: rtl/gray_sobel_edge.sv
// rtl/gray_sobel_edge.sv - 3x3 Sobel edge detector on a 12-bit gray stream
// Three-stage pipeline: line-buffer read/window shift, gradients, magnitude/threshold.
module gray_sobel_edge #(
  parameter int IMG_WIDTH = 640
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic [11:0] iGray,
  input  logic        iDVAL,
  input  logic        iSOF,
  input  logic [11:0] iThresh,
  output logic [11:0] oEdge,
  output logic        oBinary,
  output logic        oDVAL
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);

  logic [XW-1:0] x;
  logic [10:0]   y;
  logic [XW-1:0] cur_x;
  logic [10:0]   cur_y;

  // A qualified start-of-frame makes this very pixel (0,0).
  assign cur_x = iSOF ? '0 : x;
  assign cur_y = iSOF ? '0 : y;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      x <= '0;
      y <= '0;
    end else if (iDVAL) begin
      if (cur_x == X_LAST) begin
        x <= '0;
        y <= (cur_y == 11'd2047) ? cur_y : cur_y + 11'd1;
      end else begin
        x <= cur_x + XW'(1);
        y <= cur_y;
      end
    end
  end

  logic [11:0] lb1 [0:IMG_WIDTH-1];
  logic [11:0] lb2 [0:IMG_WIDTH-1];
  logic [11:0] lb1_rd;
  logic [11:0] lb2_rd;

  assign lb1_rd = lb1[cur_x];
  assign lb2_rd = lb2[cur_x];

  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      lb2[cur_x] <= lb1_rd;
      lb1[cur_x] <= iGray;
    end
  end

  // win[r][c]: row 0 = y-2 (top), column 2 = newest (x)
  logic [2:0][2:0][11:0] win;
  logic                  v1;
  logic                  b1;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      win <= '0;
      v1  <= 1'b0;
      b1  <= 1'b0;
    end else begin
      v1 <= iDVAL;
      b1 <= iDVAL && ((cur_x <= XW'(1)) || (cur_y <= 11'd1));
      if (iDVAL) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb2_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= iGray;
      end
    end
  end

  function automatic logic signed [14:0] ext(input logic [11:0] p);
    return $signed({3'b000, p});
  endfunction

  logic signed [14:0] gx_next;
  logic signed [14:0] gy_next;

  always_comb begin
    gx_next = ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2])
            - ext(win[0][0]) - (ext(win[1][0]) <<< 1) - ext(win[2][0]);
    gy_next = ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2])
            - ext(win[0][0]) - (ext(win[0][1]) <<< 1) - ext(win[0][2]);
  end

  logic signed [14:0] gx;
  logic signed [14:0] gy;
  logic               v2;
  logic               b2;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      gx <= '0;
      gy <= '0;
      v2 <= 1'b0;
      b2 <= 1'b0;
    end else begin
      gx <= gx_next;
      gy <= gy_next;
      v2 <= v1;
      b2 <= b1;
    end
  end

  logic [14:0] ax;
  logic [14:0] ay;
  logic [15:0] mag;
  logic [11:0] edge_next;

  always_comb begin
    ax  = gx[14] ? $unsigned(-gx) : $unsigned(gx);
    ay  = gy[14] ? $unsigned(-gy) : $unsigned(gy);
    mag = {1'b0, ax} + {1'b0, ay};
    if (b2)
      edge_next = '0;
    else if (mag > 16'd4095)
      edge_next = 12'hFFF;
    else
      edge_next = mag[11:0];
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oEdge   <= '0;
      oBinary <= 1'b0;
      oDVAL   <= 1'b0;
    end else begin
      oEdge   <= edge_next;
      oBinary <= (edge_next >= iThresh);
      oDVAL   <= v2;
    end
  end

endmodule

// File: tb/tb_gray_sobel_edge.sv
// tb/tb_gray_sobel_edge.sv - scoreboard bench for gray_sobel_edge
module tb_gray_sobel_edge;

  localparam int W = 8;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b1;
  logic [11:0] iGray = '0;
  logic        iDVAL = 1'b0;
  logic        iSOF = 1'b0;
  logic [11:0] iThresh = '0;
  logic [11:0] oEdge;
  logic        oBinary;
  logic        oDVAL;

  gray_sobel_edge #(.IMG_WIDTH(W)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iGray(iGray), .iDVAL(iDVAL), .iSOF(iSOF),
    .iThresh(iThresh), .oEdge(oEdge), .oBinary(oBinary), .oDVAL(oDVAL)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    int due;
    int edge_v;
    int bin;
  } exp_t;

  exp_t q[$];
  int   img [0:2][0:W-1];
  int   mx = 0;
  int   my = 0;
  int   thresh = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int pix(input int yy, input int xx);
    return img[yy % 3][xx];
  endfunction

  task automatic model_push(input int g, input bit sof);
    int cx, cy, gx, gy, e;
    exp_t ent;
    if (sof) begin cx = 0; cy = 0; end
    else begin cx = mx; cy = my; end
    if (cx == W - 1) begin
      mx = 0;
      my = (cy < 2047) ? cy + 1 : cy;
    end else begin
      mx = cx + 1;
      my = cy;
    end
    img[cy % 3][cx] = g;
    if (cx < 2 || cy < 2) begin
      e = 0;
    end else begin
      gx = (pix(cy-2, cx) + 2*pix(cy-1, cx) + pix(cy, cx))
         - (pix(cy-2, cx-2) + 2*pix(cy-1, cx-2) + pix(cy, cx-2));
      gy = (pix(cy, cx-2) + 2*pix(cy, cx-1) + pix(cy, cx))
         - (pix(cy-2, cx-2) + 2*pix(cy-2, cx-1) + pix(cy-2, cx));
      e = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (e > 4095) e = 4095;
    end
    ent.due = cyc + 3;
    ent.edge_v = e;
    ent.bin = (e >= thresh) ? 1 : 0;
    q.push_back(ent);
  endtask

  task automatic px(input int g, input bit dv, input bit sof);
    @(negedge iCLK);
    iGray = 12'(g);
    iDVAL = dv;
    iSOF = sof;
    if (dv) model_push(g, sof);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(0, 1'b0, 1'b0);
  endtask

  task automatic set_thresh(input int t);
    thresh = t;
    iThresh = 12'(t);
  endtask

  task automatic do_reset();
    #2 iRST_n = 1'b0;
    #1;
    chk("rst_edge", int'(oEdge), 0);
    chk("rst_binary", int'(oBinary), 0);
    chk("rst_dval", int'(oDVAL), 0);
    q.delete();
    mx = 0;
    my = 0;
    iDVAL = 1'b0;
    iSOF = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST_n = 1'b1;
  endtask

  // Output side of the scoreboard: oDVAL must appear exactly when an entry falls due.
  always @(negedge iCLK) begin
    bit ev;
    exp_t e;
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk("dval", int'(oDVAL), int'(ev));
    if (ev) begin
      e = q.pop_front();
      chk("edge", int'(oEdge), e.edge_v);
      chk("binary", int'(oBinary), e.bin);
    end
  end

  initial begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++) img[r][c] = 0;

    do_reset();

    // flat field, threshold 0: every output edge=0, binary=1 (borders too)
    set_thresh(0);
    for (int l = 0; l < 4; l++)
      for (int x = 0; x < W; x++) px(1000, 1'b1, 1'b0);
    idle(6);

    // horizontal ramp
    set_thresh(50);
    for (int l = 0; l < 4; l++)
      for (int x = 0; x < W; x++) px(10 * x, 1'b1, (l == 0 && x == 0));
    idle(6);

    // vertical step, saturates at the edge columns
    set_thresh(100);
    for (int l = 0; l < 4; l++)
      for (int x = 0; x < W; x++) px((x < 4) ? 0 : 4095, 1'b1, (l == 0 && x == 0));
    idle(6);

    // ramp with a gap after every valid
    set_thresh(50);
    for (int l = 0; l < 4; l++)
      for (int x = 0; x < W; x++) begin
        px(10 * x, 1'b1, (l == 0 && x == 0));
        px(0, 1'b0, 1'b0);
      end
    idle(6);

    // start of frame arriving mid-line 2 at x=5
    set_thresh(300);
    for (int l = 0; l < 2; l++)
      for (int x = 0; x < W; x++) px($urandom_range(0, 4095), 1'b1, (l == 0 && x == 0));
    for (int x = 0; x < 5; x++) px($urandom_range(0, 4095), 1'b1, 1'b0);
    px($urandom_range(0, 4095), 1'b1, 1'b1);
    for (int i = 0; i < 3 * W; i++) px($urandom_range(0, 4095), 1'b1, 1'b0);
    idle(6);

    // random data with random gaps, then reset in the middle of line 3
    set_thresh($urandom_range(0, 4095));
    for (int i = 0; i < 3 * W + 4; i++) begin
      px($urandom_range(0, 4095), 1'b1, (i == 0));
      if ($urandom_range(0, 2) == 0) px(0, 1'b0, 1'b0);
    end
    do_reset();
    for (int i = 0; i < 3 * W; i++) px($urandom_range(0, 4095), 1'b1, 1'b0);

    idle(10);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
